// File: rtl/esc_quad_drv.sv
// Four-channel ESC PWM driver: frame-synchronous, double-buffered speeds, arming sequencer.
// Optional build macro SLEW_LIMIT_EN limits per-frame speed change to MAX_STEP while ARMED.
module esc_quad_drv #(
    parameter int unsigned PERIOD_CYCLES = 1048576,
    parameter int unsigned MIN_PULSE     = 50000,
    parameter int unsigned ARM_FRAMES    = 50,
    parameter int unsigned MAX_STEP      = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic        spd_vld,
    input  logic        arm,
    output logic        frnt,
    output logic        bck,
    output logic        lft,
    output logic        rght,
    output logic        armed,
    output logic        upd_pend,
    output logic        frm
);

    localparam int unsigned CW = $clog2(PERIOD_CYCLES);
    localparam int unsigned AW = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;

`ifdef SLEW_LIMIT_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    // Without slew limiting the step covers the full 11-bit range, so active copies the target.
    localparam logic [10:0] STEP = (SLEW && MAX_STEP < 2047) ? 11'(MAX_STEP) : 11'd2047;

    typedef enum logic [1:0] {
        StDisarmed,
        StArming,
        StArmed
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     arm_cnt_q, arm_cnt_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              boundary;
    logic [31:0]       cnt_nxt;

    logic [3:0][10:0]  spd_in;
    logic [3:0][10:0]  tgt;
    logic [3:0][10:0]  pend_q, pend_d;
    logic [3:0][10:0]  act_q, act_d;
    logic              upd_pend_q, upd_pend_d;
    logic [3:0][16:0]  pw;
    logic [3:0]        pwm_q, pwm_d;

    function automatic logic [10:0] step_toward(input logic [10:0] cur, input logic [10:0] dst);
        if (dst > cur) begin
            return ((dst - cur) > STEP) ? cur + STEP : dst;
        end
        return ((cur - dst) > STEP) ? cur - STEP : dst;
    endfunction

    assign spd_in   = {rght_spd, lft_spd, bck_spd, frnt_spd};
    assign boundary = (cnt_q == CW'(PERIOD_CYCLES - 1));
    assign cnt_nxt  = 32'(cnt_q) + 32'd1;

    always_comb begin
        cnt_d = boundary ? '0 : cnt_q + 1'b1;
    end

    // Arming sequencer; every transition waits for a frame boundary.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        if (boundary) begin
            case (state_q)
                StDisarmed: begin
                    if (arm) begin
                        state_d   = StArming;
                        arm_cnt_d = '0;
                    end
                end
                StArming: begin
                    if (!arm) begin
                        state_d = StDisarmed;
                    end else if (arm_cnt_q == AW'(ARM_FRAMES - 1)) begin
                        state_d = StArmed;
                    end else begin
                        arm_cnt_d = arm_cnt_q + 1'b1;
                    end
                end
                StArmed: begin
                    if (!arm) begin
                        state_d = StDisarmed;
                    end
                end
                default: state_d = StDisarmed;
            endcase
        end
    end

    // A strobe landing on the boundary cycle bypasses pending and feeds active directly.
    always_comb begin
        pend_d     = pend_q;
        act_d      = act_q;
        upd_pend_d = upd_pend_q;
        tgt        = spd_vld ? spd_in : pend_q;
        if (spd_vld) begin
            pend_d     = spd_in;
            upd_pend_d = 1'b1;
        end
        if (boundary) begin
            if (state_d == StDisarmed) begin
                act_d = '0;
            end else if (state_d == StArmed) begin
                for (int ch = 0; ch < 4; ch++) begin
                    act_d[ch] = step_toward(act_q[ch], tgt[ch]);
                end
                upd_pend_d = (act_d != tgt);
            end
        end
    end

    always_comb begin
        pw    = '0;
        pwm_d = pwm_q;
        for (int ch = 0; ch < 4; ch++) begin
            if (state_q == StArming) begin
                pw[ch] = 17'(MIN_PULSE);
            end else begin
                pw[ch] = 17'(MIN_PULSE) + 17'(act_q[ch]) * 17'd3;
            end
            if (boundary) begin
                pwm_d[ch] = (state_d != StDisarmed);
            end else if (cnt_nxt == 32'(pw[ch])) begin
                pwm_d[ch] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StDisarmed;
            arm_cnt_q  <= '0;
            cnt_q      <= '0;
            pend_q     <= '0;
            act_q      <= '0;
            upd_pend_q <= 1'b0;
            pwm_q      <= '0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            act_q      <= act_d;
            upd_pend_q <= upd_pend_d;
            pwm_q      <= pwm_d;
        end
    end

    assign frnt     = pwm_q[0];
    assign bck      = pwm_q[1];
    assign lft      = pwm_q[2];
    assign rght     = pwm_q[3];
    assign armed    = (state_q == StArmed);
    assign upd_pend = upd_pend_q;
    assign frm      = (cnt_q == '0);

endmodule

// File: tb/tb_esc_quad_drv.sv
// Scoreboard bench for esc_quad_drv: per-frame expected widths/status queued, then measured.
module tb_esc_quad_drv;

    localparam int unsigned PERIOD = 6250;
    localparam int unsigned MINP   = 100;
    localparam int unsigned ARMF   = 2;
    localparam int unsigned MSTEP  = 64;

    typedef logic [3:0][10:0] spd4_t;
    typedef struct {
        int   w [4];
        logic armed;
        logic pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] frnt_spd = '0, bck_spd = '0, lft_spd = '0, rght_spd = '0;
    logic        spd_vld = 1'b0;
    logic        arm = 1'b0;
    logic        frnt, bck, lft, rght, armed, upd_pend, frm;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    esc_quad_drv #(
        .PERIOD_CYCLES(PERIOD),
        .MIN_PULSE    (MINP),
        .ARM_FRAMES   (ARMF),
        .MAX_STEP     (MSTEP)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .frnt_spd(frnt_spd),
        .bck_spd (bck_spd),
        .lft_spd (lft_spd),
        .rght_spd(rght_spd),
        .spd_vld (spd_vld),
        .arm     (arm),
        .frnt    (frnt),
        .bck     (bck),
        .lft     (lft),
        .rght    (rght),
        .armed   (armed),
        .upd_pend(upd_pend),
        .frm     (frm)
    );

    function automatic int pw_of(input int s);
        return int'(MINP) + 3 * s;
    endfunction

    function automatic spd4_t mk_spd(input int a, input int b, input int c, input int d);
        spd4_t s;
        s[0] = 11'(a);
        s[1] = 11'(b);
        s[2] = 11'(c);
        s[3] = 11'(d);
        return s;
    endfunction

    task automatic push_exp(input int a, input int b, input int c, input int d,
                            input logic armd, input logic pend);
        exp_t e;
        e.w[0] = a;
        e.w[1] = b;
        e.w[2] = c;
        e.w[3] = d;
        e.armed = armd;
        e.pend = pend;
        sb.push_back(e);
    endtask

    task automatic drive_spd(input spd4_t s);
        frnt_spd = s[0];
        bck_spd  = s[1];
        lft_spd  = s[2];
        rght_spd = s[3];
    endtask

    // Measures one frame starting at the cnt==0 cycle; optional strobes and arm drop by cycle index.
    task automatic run_frame(input int vld_at, input spd4_t sa, input int vld2_at,
                             input spd4_t sb2, input int drop_at);
        int         w [4];
        int         frms;
        int         waited;
        logic       armed0;
        logic       pend_end;
        logic [3:0] first;
        logic [3:0] first_exp;
        exp_t       e;
        waited = 0;
        while (frm !== 1'b1 && waited < int'(PERIOD) + 2) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (frm !== 1'b1) begin
            failures++;
            $display("FAIL frame_sync frm=%b required 1", frm);
        end
        for (int k = 0; k < 4; k++) w[k] = 0;
        frms     = 0;
        pend_end = 1'bx;
        armed0   = armed;
        first    = {rght, lft, bck, frnt};
        for (int i = 0; i < int'(PERIOD); i++) begin
            if (frnt === 1'b1) w[0]++;
            if (bck === 1'b1) w[1]++;
            if (lft === 1'b1) w[2]++;
            if (rght === 1'b1) w[3]++;
            if (frm === 1'b1) frms++;
            if (i == int'(PERIOD) - 1) pend_end = upd_pend;
            spd_vld = 1'b0;
            if (i == vld_at) begin
                drive_spd(sa);
                spd_vld = 1'b1;
            end
            if (i == vld2_at) begin
                drive_spd(sb2);
                spd_vld = 1'b1;
            end
            if (i == drop_at) arm = 1'b0;
            @(negedge clk);
        end
        spd_vld = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty size=%0d required >0", sb.size());
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (w[k] !== e.w[k]) begin
                failures++;
                $display("FAIL width_ch%0d got=%0d required=%0d", k, w[k], e.w[k]);
            end
            first_exp[k] = (e.w[k] != 0);
        end
        checks++;
        if (first !== first_exp) begin
            failures++;
            $display("FAIL rise_at_cnt0 got=%b required=%b", first, first_exp);
        end
        checks++;
        if (armed0 !== e.armed) begin
            failures++;
            $display("FAIL armed got=%b required=%b", armed0, e.armed);
        end
        checks++;
        if (pend_end !== e.pend) begin
            failures++;
            $display("FAIL upd_pend got=%b required=%b", pend_end, e.pend);
        end
        checks++;
        if (frms !== 1) begin
            failures++;
            $display("FAIL frm_count got=%0d required=1", frms);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rght, lft, bck, frnt} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_pwm got=%b required=0000", {rght, lft, bck, frnt});
        end
        checks++;
        if (armed !== 1'b0 || upd_pend !== 1'b0) begin
            failures++;
            $display("FAIL reset_status armed=%b upd_pend=%b required 0 0", armed, upd_pend);
        end
        checks++;
        if (frm !== 1'b1) begin
            failures++;
            $display("FAIL reset_frm got=%b required=1", frm);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_disarmed();
        push_exp(0, 0, 0, 0, 1'b0, 1'b0);
        run_frame(-1, '0, -1, '0, -1);
    endtask

    task automatic test_arming();
        arm = 1'b1;
        push_exp(0, 0, 0, 0, 1'b0, 1'b0);
        for (int f = 0; f < int'(ARMF); f++) push_exp(MINP, MINP, MINP, MINP, 1'b0, 1'b0);
        push_exp(MINP, MINP, MINP, MINP, 1'b1, 1'b0);
        for (int f = 0; f < int'(ARMF) + 2; f++) run_frame(-1, '0, -1, '0, -1);
    endtask

    task automatic test_speed_update();
        push_exp(MINP, MINP, MINP, MINP, 1'b1, 1'b1);
        run_frame(10, mk_spd(100, 0, 2047, 1), -1, '0, -1);
        push_exp(pw_of(100), pw_of(0), pw_of(2047), pw_of(1), 1'b1, 1'b0);
        run_frame(-1, '0, -1, '0, -1);
    endtask

    task automatic test_boundary_bypass();
        push_exp(pw_of(100), pw_of(0), pw_of(2047), pw_of(1), 1'b1, 1'b0);
        run_frame(int'(PERIOD) - 1, mk_spd(50, 10, 0, 2000), -1, '0, -1);
        push_exp(pw_of(50), pw_of(10), pw_of(0), pw_of(2000), 1'b1, 1'b0);
        run_frame(-1, '0, -1, '0, -1);
    endtask

    task automatic test_back_to_back();
        push_exp(pw_of(50), pw_of(10), pw_of(0), pw_of(2000), 1'b1, 1'b1);
        run_frame(10, mk_spd(7, 7, 7, 7), 11, mk_spd(100, 100, 100, 100), -1);
    endtask

    task automatic test_disarm();
        push_exp(pw_of(100), pw_of(100), pw_of(100), pw_of(100), 1'b1, 1'b0);
        run_frame(-1, '0, -1, '0, 200);
        // Speeds captured while disarmed stay pending and are not applied.
        push_exp(0, 0, 0, 0, 1'b0, 1'b1);
        run_frame(10, mk_spd(5, 5, 5, 5), -1, '0, -1);
        push_exp(0, 0, 0, 0, 1'b0, 1'b1);
        run_frame(-1, '0, -1, '0, -1);
    endtask

    initial begin
        test_reset();
        test_disarmed();
        test_arming();
        test_speed_update();
        test_boundary_bypass();
        test_back_to_back();
        test_disarm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
